mips_seq_divider: RTL and testbench

- Multi-cycle restoring divider that executes MIPS div and divu, producing the LO (quotient) and HI (remainder) values.
- Sits beside the 32-bit ALU in the execute stage and is the inverse-arithmetic counterpart to the add/sub/slt datapath.
- Takes a one-cycle start pulse and returns the results after a fixed latency, with a busy/done handshake.
- The processor control stalls on busy and latches quotient and remainder into HI/LO on done.

---
 rtl/mips_div_pkg.sv | 15 +
 rtl/div_restore_step.sv | 26 ++
 rtl/mips_seq_divider.sv | 139 +++++++++++++
 tb/tb_mips_seq_divider.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared definitions for the sequential MIPS div/divu unit.
package mips_div_pkg;

  localparam int WIDTH_DEF   = 32;
  // Start edge to the cycle in which done is high, counted in clock cycles.
  localparam int DIV_LATENCY = WIDTH_DEF + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when the shifted partial remainder is large enough.
// rem_i carries the partial remainder without its MSB, which is always zero
// before a shift because the remainder stays below the divisor.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-2:0] rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtraction one bit wider than the operands; its MSB is the borrow.
  always_comb begin
    shifted = {1'b0, rem_i, q_msb_i};
    trial   = shifted - {1'b0, dvsr_i};
    q_bit_o = ~trial[WIDTH];
    rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for MIPS div/divu. LO = quotient, HI = remainder.
// Works on magnitudes and applies the MIPS sign rules in a single fix-up cycle.
module mips_seq_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend as presented, for the divide-by-zero remainder
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_o_q, quo_o_d;
  logic [WIDTH-1:0] rem_o_q, rem_o_d;
  logic             dbz_o_q, dbz_o_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  // Two's complement negate when neg is set; also yields |v| for negative v.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return neg ? $unsigned(-s) : v;
  endfunction

  assign neg_a = signed_op & dividend[WIDTH-1];
  assign neg_b = signed_op & divisor[WIDTH-1];

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q[WIDTH-2:0]),
    .q_msb_i (quo_q[WIDTH-1]),
    .dvsr_i  (dvsr_q),
    .rem_o   (step_rem),
    .q_bit_o (step_bit)
  );

  // Next-state and datapath update for the IDLE/RUN/FIX/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dbz_d   = dbz_q;
    quo_o_d = quo_o_q;
    rem_o_d = rem_o_q;
    dbz_o_d = dbz_o_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d = RUN;
          quo_d   = cond_neg(dividend, neg_a);
          dvsr_d  = cond_neg(divisor, neg_b);
          dvd_d   = dividend;
          neg_q_d = neg_a ^ neg_b;
          neg_r_d = neg_a;
          dbz_d   = (divisor == '0);
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quo_o_d = dbz_q ? '1    : cond_neg(quo_q, neg_q_q);
        rem_o_d = dbz_q ? dvd_q : cond_neg(rem_q, neg_r_q);
        dbz_o_d = dbz_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dbz_q   <= 1'b0;
      quo_o_q <= '0;
      rem_o_q <= '0;
      dbz_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dbz_q   <= dbz_d;
      quo_o_q <= quo_o_d;
      rem_o_q <= rem_o_d;
      dbz_o_q <= dbz_o_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quo_o_q;
  assign remainder   = rem_o_q;
  assign div_by_zero = dbz_o_q;

endmodule

// File: tb/tb_mips_seq_divider.sv
// Scoreboard bench for mips_seq_divider: directed corner cases plus random divides.
module tb_mips_seq_divider;
  import mips_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  mips_seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: MIPS div/divu semantics from plain integer arithmetic.
  function automatic exp_t model(input logic sop, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sbv;
    e.acc = 0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
    end else if (sop) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      e.q = 32'(sa / sbv); e.r = 32'(sa % sbv); e.dbz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_done: got done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        check("latency", 32'(cyc - e.acc + 1), 32'(DIV_LATENCY));
      end
    end
  end

  // Issue one divide. With now=0 wait for the unit to leave busy first;
  // with now=1 drive start in the current cycle.
  task automatic issue(input logic sop, input logic [31:0] a, input logic [31:0] b, input bit now);
    exp_t e;
    int t;
    if (!now) begin
      t = 0;
      @(negedge clk);
      while (busy && t < 200) begin @(negedge clk); t++; end
      if (busy) check("issue_wait_busy", {31'd0, busy}, 32'd0);
    end
    signed_op = sop; dividend = a; divisor = b; start = 1'b1;
    e = model(sop, a, b);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    start = 1'b0;
    signed_op = 1'($urandom_range(0, 1));
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    check("drain_pending", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, t;
    bit seen;
    logic [31:0] a, b;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    // divu 100/7 with busy-cycle count
    issue(1'b0, 32'd100, 32'd7, 1'b0);
    bc = 0; seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) bc++;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_cycles", 32'(bc), 32'(DIV_LATENCY - 1));
    drain();

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(1'b0, 32'd5, 32'd0, 1'b0);
    issue(1'b0, 32'd12, 32'd4, 1'b0);
    issue(1'b1, 32'hFFFF_FFF6, 32'd0, 1'b0);
    drain();

    // starts while busy must be ignored
    issue(1'b0, 32'd1000, 32'd33, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 10 || k == 20);
      if (start) begin dividend = $urandom; divisor = $urandom; end
    end
    start = 1'b0;
    drain();

    // start in the done cycle
    issue(1'b1, 32'hFFFF_FF00, 32'd7, 1'b0);
    t = 0; seen = 0;
    while (!seen && t < 100) begin @(negedge clk); t++; if (done) seen = 1; end
    check("b2b_done_seen", {31'd0, seen}, 32'd1);
    issue(1'b0, 32'd77, 32'd10, 1'b1);
    drain();

    // reset mid-operation
    issue(1'b0, 32'd123456, 32'd789, 1'b0);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_quotient", quotient, 32'd0);
    check("mid_rst_remainder", remainder, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'd9, 32'd3, 1'b0);
    drain();

    // random mix
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(2, 300));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      issue(1'($urandom_range(0, 1)), a, b, 1'b0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
